lq_mem_issue: RTL and testbench

- Sits between the load-queue entries and the data-memory port; it is the LQ's downstream memory stage.
- Each cycle it selects one load whose address is resolved and not yet requested, computes its address, and issues a BUS_LOAD.
- It records the memory tag returned on acceptance. When the matching response arrives, it steers the data back to the owning entry.
- On an LQ flush it retires all outstanding tags as stale, so late responses are dropped.

---
 rtl/lq_mem_issue_pkg.sv | 17 +
 rtl/lq_mem_issue_if.sv | 23 ++
 rtl/lq_mem_issue_rr_arbiter.sv | 31 +++
 rtl/lq_mem_issue.sv | 152 +++++++++++++++
 tb/tb_lq_mem_issue.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lq_mem_issue_pkg.sv
// Shared definitions for the load-queue memory issue stage: bus command
// encodings, default sizing and the displacement sign-extension helper.
package lq_pkg;

    localparam int LQ_SIZE_DEFAULT   = 8;
    localparam int MEM_TAG_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        BUS_NONE = 2'h0,
        BUS_LOAD = 2'h1
    } bus_cmd_e;

    function automatic logic [63:0] sext16to64(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

endpackage

// File: rtl/lq_mem_issue_if.sv
// Data-memory port bundle: request command/address out, acceptance tag,
// response tag and response data back.
interface lq_mem_issue_if
    import lq_pkg::*;
#(
    parameter int MEM_TAG_W = MEM_TAG_W_DEFAULT
);
    bus_cmd_e               proc2Dmem_command;
    logic [63:0]            proc2Dmem_addr;
    logic [MEM_TAG_W-1:0]   Dmem2proc_response;
    logic [63:0]            Dmem2proc_data;
    logic [MEM_TAG_W-1:0]   Dmem2proc_tag;

    modport master (
        output proc2Dmem_command, proc2Dmem_addr,
        input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
    );

    modport slave (
        input  proc2Dmem_command, proc2Dmem_addr,
        output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
    );
endinterface

// File: rtl/lq_mem_issue_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at base_ptr and wrapping,
// returning the first requester as one-hot grant plus its index.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] base_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    // Pick the first asserted request at or after base_ptr, modulo N
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(base_ptr) + k) % N;
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lq_mem_issue.sv
// Load-queue memory issue stage: picks one ready load per cycle, sends it to
// data memory, remembers the acceptance tag, and steers returning data to the
// owning entry. A flush marks all outstanding tags stale so late data is lost.
module lq_mem_issue
    import lq_pkg::*;
#(
    parameter int LQ_SIZE   = LQ_SIZE_DEFAULT,
    parameter int MEM_TAG_W = MEM_TAG_W_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      lq_clean,
    input  logic [LQ_SIZE-1:0]        lq_inuse,
    input  logic [LQ_SIZE-1:0]        lq_addr_valid,
    input  logic [LQ_SIZE-1:0]        lq_requested,
    input  logic [LQ_SIZE-1:0]        lq_mem_value_valid,
    input  logic [LQ_SIZE*64-1:0]     lq_opb,
    input  logic [LQ_SIZE*32-1:0]     lq_inst,
    lq_mem_issue_if.master            mem,
    output logic [LQ_SIZE-1:0]        lq_request2mem,
    output logic [63:0]               lq_mem_data_out,
    output logic [LQ_SIZE-1:0]        lq_mem_data_valid,
    output logic [$clog2(LQ_SIZE):0]  lq_outstanding
);

    localparam int IDX_W = $clog2(LQ_SIZE);
    localparam int NTAGS = 1 << MEM_TAG_W;
    localparam int CNT_W = $clog2(LQ_SIZE) + 1;

    logic [LQ_SIZE-1:0]    pending_q, pending_d;
    logic [MEM_TAG_W-1:0]  tag_tbl_q [LQ_SIZE];
    logic [MEM_TAG_W-1:0]  tag_tbl_d [LQ_SIZE];
    logic [NTAGS-1:0]      stale_q, stale_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [LQ_SIZE-1:0]    elig;
    logic [LQ_SIZE-1:0]    grant;
    logic [LQ_SIZE-1:0]    match;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  accept;

    // Entries ready to issue; nothing is eligible during a flush or in reset
    always_comb begin
        elig = lq_inuse & lq_addr_valid & ~lq_requested & ~lq_mem_value_valid
             & ~pending_q & {LQ_SIZE{~lq_clean & reset}};
    end

    rr_arbiter #(
        .N     (LQ_SIZE),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (elig),
        .base_ptr  (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (grant_valid)
    );

    // Drive the winning load's aligned effective address; accepted when memory tags it
    always_comb begin
        mem.proc2Dmem_command = BUS_NONE;
        mem.proc2Dmem_addr    = '0;
        lq_request2mem        = '0;
        accept                = 1'b0;
        if (grant_valid) begin
            mem.proc2Dmem_command = BUS_LOAD;
            mem.proc2Dmem_addr    = (lq_opb[int'(grant_idx)*64 +: 64]
                                  + sext16to64(lq_inst[int'(grant_idx)*32 +: 16]))
                                  & ~64'h7;
            accept = (mem.Dmem2proc_response != '0);
            if (accept) begin
                lq_request2mem = grant;
            end
        end
    end

    // Route a returning response to the pending entry holding its tag, unless stale or flushing
    always_comb begin
        match           = '0;
        lq_mem_data_out = '0;
        if (mem.Dmem2proc_tag != '0 && !lq_clean && !stale_q[mem.Dmem2proc_tag]) begin
            for (int i = 0; i < LQ_SIZE; i++) begin
                if (pending_q[i] && tag_tbl_q[i] == mem.Dmem2proc_tag) begin
                    match[i] = 1'b1;
                end
            end
        end
        if (|match) begin
            lq_mem_data_out = mem.Dmem2proc_data;
        end
        lq_mem_data_valid = match;
    end

    // Next state: return clears pending, flush marks tags stale, accept records the new tag last
    always_comb begin
        pending_d = pending_q & ~match;
        tag_tbl_d = tag_tbl_q;
        stale_d   = stale_q;
        rr_ptr_d  = rr_ptr_q;
        if (mem.Dmem2proc_tag != '0 && stale_q[mem.Dmem2proc_tag]) begin
            stale_d[mem.Dmem2proc_tag] = 1'b0;
        end
        if (lq_clean) begin
            for (int i = 0; i < LQ_SIZE; i++) begin
                if (pending_q[i]) begin
                    stale_d[tag_tbl_q[i]] = 1'b1;
                    pending_d[i]          = 1'b0;
                end
            end
        end
        if (accept) begin
            pending_d[grant_idx]            = 1'b1;
            tag_tbl_d[grant_idx]            = mem.Dmem2proc_response;
            stale_d[mem.Dmem2proc_response] = 1'b0;
            rr_ptr_d = (grant_idx == IDX_W'(LQ_SIZE - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Number of entries waiting on memory data
    always_comb begin
        lq_outstanding = '0;
        for (int i = 0; i < LQ_SIZE; i++) begin
            lq_outstanding = lq_outstanding + CNT_W'(pending_q[i]);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            stale_q   <= '0;
            rr_ptr_q  <= '0;
            for (int i = 0; i < LQ_SIZE; i++) begin
                tag_tbl_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            stale_q   <= stale_d;
            rr_ptr_q  <= rr_ptr_d;
            for (int i = 0; i < LQ_SIZE; i++) begin
                tag_tbl_q[i] <= tag_tbl_d[i];
            end
        end
    end

    // An entry must never be freed while its load is still outstanding
    a_no_free_while_pending: assert property (
        @(posedge clock) disable iff (!reset) ((pending_q & ~lq_inuse) == '0)
    );

endmodule

// File: tb/tb_lq_mem_issue.sv
// Directed testbench for lq_mem_issue: each task drives one scenario and
// compares the combinational outputs against hand-computed values.
module tb_lq_mem_issue;
    import lq_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         lq_clean;
    logic [7:0]   lq_inuse, lq_addr_valid, lq_requested, lq_mem_value_valid;
    logic [511:0] lq_opb;
    logic [255:0] lq_inst;
    logic [7:0]   lq_request2mem, lq_mem_data_valid;
    logic [63:0]  lq_mem_data_out;
    logic [3:0]   lq_outstanding;

    int vectors     = 0;
    int miscompares = 0;

    lq_mem_issue_if #(.MEM_TAG_W(4)) mem ();

    lq_mem_issue #(.LQ_SIZE(8), .MEM_TAG_W(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .lq_clean           (lq_clean),
        .lq_inuse           (lq_inuse),
        .lq_addr_valid      (lq_addr_valid),
        .lq_requested       (lq_requested),
        .lq_mem_value_valid (lq_mem_value_valid),
        .lq_opb             (lq_opb),
        .lq_inst            (lq_inst),
        .mem                (mem),
        .lq_request2mem     (lq_request2mem),
        .lq_mem_data_out    (lq_mem_data_out),
        .lq_mem_data_valid  (lq_mem_data_valid),
        .lq_outstanding     (lq_outstanding)
    );

    always #5 clock = ~clock;

    task automatic clear_inputs();
        lq_clean = 1'b0; lq_inuse = '0; lq_addr_valid = '0; lq_requested = '0;
        lq_mem_value_valid = '0; lq_opb = '0; lq_inst = '0;
        mem.Dmem2proc_response = '0; mem.Dmem2proc_data = '0; mem.Dmem2proc_tag = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        clear_inputs();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        step();
        lq_inuse = 8'h04; lq_addr_valid = 8'h04;
        mem.Dmem2proc_response = 4'd3; mem.Dmem2proc_tag = 4'd3; mem.Dmem2proc_data = 64'hAA;
        #1;
        vectors++; if (mem.proc2Dmem_command !== BUS_NONE) begin miscompares++; $display("FAIL reset_cmd: got %0d expected %0d", mem.proc2Dmem_command, BUS_NONE); end
        vectors++; if (mem.proc2Dmem_addr !== 64'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", mem.proc2Dmem_addr); end
        vectors++; if (lq_request2mem !== 8'h00) begin miscompares++; $display("FAIL reset_req: got %h expected 00", lq_request2mem); end
        vectors++; if (lq_mem_data_valid !== 8'h00) begin miscompares++; $display("FAIL reset_dvalid: got %h expected 00", lq_mem_data_valid); end
        vectors++; if (lq_mem_data_out !== 64'h0) begin miscompares++; $display("FAIL reset_dout: got %h expected 0", lq_mem_data_out); end
        vectors++; if (lq_outstanding !== 4'd0) begin miscompares++; $display("FAIL reset_outstanding: got %0d expected 0", lq_outstanding); end
    endtask

    task automatic test_single_load();
        do_reset();
        step();
        lq_inuse = 8'h04; lq_addr_valid = 8'h04;
        lq_opb[2*64 +: 64] = 64'h1000; lq_inst[2*32 +: 32] = 32'h0000FFF8;
        mem.Dmem2proc_response = 4'd3;
        #1;
        vectors++; if (mem.proc2Dmem_command !== BUS_LOAD) begin miscompares++; $display("FAIL single_cmd: got %0d expected %0d", mem.proc2Dmem_command, BUS_LOAD); end
        vectors++; if (mem.proc2Dmem_addr !== 64'h0FF8) begin miscompares++; $display("FAIL single_addr: got %h expected 0ff8", mem.proc2Dmem_addr); end
        vectors++; if (lq_request2mem !== 8'h04) begin miscompares++; $display("FAIL single_req: got %h expected 04", lq_request2mem); end
        step();
        mem.Dmem2proc_response = '0; mem.Dmem2proc_tag = 4'd3; mem.Dmem2proc_data = 64'hDEAD;
        lq_mem_value_valid = 8'h04;
        #1;
        vectors++; if (lq_outstanding !== 4'd1) begin miscompares++; $display("FAIL single_outstanding: got %0d expected 1", lq_outstanding); end
        vectors++; if (lq_mem_data_valid !== 8'h04) begin miscompares++; $display("FAIL single_dvalid: got %h expected 04", lq_mem_data_valid); end
        vectors++; if (lq_mem_data_out !== 64'hDEAD) begin miscompares++; $display("FAIL single_dout: got %h expected dead", lq_mem_data_out); end
        step();
        mem.Dmem2proc_tag = '0;
        #1;
        vectors++; if (lq_outstanding !== 4'd0) begin miscompares++; $display("FAIL single_drain: got %0d expected 0", lq_outstanding); end
        vectors++; if (lq_mem_data_valid !== 8'h00) begin miscompares++; $display("FAIL single_dvalid_off: got %h expected 00", lq_mem_data_valid); end
    endtask

    task automatic test_round_robin();
        logic [7:0]  exp_req  [5] = '{8'h01, 8'h02, 8'h20, 8'h80, 8'h04};
        logic [63:0] exp_addr [5] = '{64'h010, 64'h110, 64'h510, 64'h0, 64'h0};
        do_reset();
        step();
        lq_inuse = 8'h23; lq_addr_valid = 8'h23;
        lq_opb[0*64 +: 64] = 64'h000; lq_inst[0*32 +: 32] = 32'h10;
        lq_opb[1*64 +: 64] = 64'h100; lq_inst[1*32 +: 32] = 32'h10;
        lq_opb[5*64 +: 64] = 64'h500; lq_inst[5*32 +: 32] = 32'h10;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) begin
                lq_inuse = 8'hA7; lq_addr_valid = 8'hA7;
            end
            mem.Dmem2proc_response = 4'(c + 1);
            #1;
            vectors++; if (lq_request2mem !== exp_req[c]) begin miscompares++; $display("FAIL rr_grant%0d: got %h expected %h", c, lq_request2mem, exp_req[c]); end
            vectors++; if (mem.proc2Dmem_addr !== exp_addr[c]) begin miscompares++; $display("FAIL rr_addr%0d: got %h expected %h", c, mem.proc2Dmem_addr, exp_addr[c]); end
            if (c == 2) begin
                step();
                mem.Dmem2proc_response = '0;
                #1;
                vectors++; if (lq_outstanding !== 4'd3) begin miscompares++; $display("FAIL rr_outstanding3: got %0d expected 3", lq_outstanding); end
                vectors++; if (mem.proc2Dmem_command !== BUS_NONE) begin miscompares++; $display("FAIL rr_idle: got %0d expected %0d", mem.proc2Dmem_command, BUS_NONE); end
            end
            step();
        end
        mem.Dmem2proc_response = '0;
        #1;
        vectors++; if (lq_outstanding !== 4'd5) begin miscompares++; $display("FAIL rr_outstanding5: got %0d expected 5", lq_outstanding); end
    endtask

    task automatic test_retry();
        do_reset();
        step();
        lq_inuse = 8'h10; lq_addr_valid = 8'h10;
        lq_opb[4*64 +: 64] = 64'h4003; lq_inst[4*32 +: 32] = 32'h0011;
        for (int c = 0; c < 4; c++) begin
            mem.Dmem2proc_response = (c == 3) ? 4'd7 : 4'd0;
            #1;
            vectors++; if (mem.proc2Dmem_command !== BUS_LOAD) begin miscompares++; $display("FAIL retry_cmd%0d: got %0d expected %0d", c, mem.proc2Dmem_command, BUS_LOAD); end
            vectors++; if (mem.proc2Dmem_addr !== 64'h4010) begin miscompares++; $display("FAIL retry_addr%0d: got %h expected 4010", c, mem.proc2Dmem_addr); end
            vectors++; if (lq_request2mem !== ((c == 3) ? 8'h10 : 8'h00)) begin miscompares++; $display("FAIL retry_req%0d: got %h expected %h", c, lq_request2mem, (c == 3) ? 8'h10 : 8'h00); end
            step();
        end
        mem.Dmem2proc_response = '0;
        #1;
        vectors++; if (lq_outstanding !== 4'd1) begin miscompares++; $display("FAIL retry_outstanding: got %0d expected 1", lq_outstanding); end
        vectors++; if (mem.proc2Dmem_command !== BUS_NONE) begin miscompares++; $display("FAIL retry_done: got %0d expected %0d", mem.proc2Dmem_command, BUS_NONE); end
    endtask

    task automatic test_flush();
        do_reset();
        step();
        lq_inuse = 8'h42; lq_addr_valid = 8'h42;
        mem.Dmem2proc_response = 4'd5;
        #1;
        vectors++; if (lq_request2mem !== 8'h02) begin miscompares++; $display("FAIL flush_acc1: got %h expected 02", lq_request2mem); end
        step();
        mem.Dmem2proc_response = 4'd9;
        #1;
        vectors++; if (lq_request2mem !== 8'h40) begin miscompares++; $display("FAIL flush_acc6: got %h expected 40", lq_request2mem); end
        step();
        lq_clean = 1'b1; lq_inuse = 8'h43; lq_addr_valid = 8'h43;
        mem.Dmem2proc_response = 4'd2;
        #1;
        vectors++; if (mem.proc2Dmem_command !== BUS_NONE) begin miscompares++; $display("FAIL flush_cmd: got %0d expected %0d", mem.proc2Dmem_command, BUS_NONE); end
        vectors++; if (lq_request2mem !== 8'h00) begin miscompares++; $display("FAIL flush_req: got %h expected 00", lq_request2mem); end
        vectors++; if (lq_outstanding !== 4'd2) begin miscompares++; $display("FAIL flush_pre: got %0d expected 2", lq_outstanding); end
        step();
        lq_clean = 1'b0; lq_inuse = '0; lq_addr_valid = '0;
        mem.Dmem2proc_response = '0; mem.Dmem2proc_tag = 4'd5; mem.Dmem2proc_data = 64'h55;
        #1;
        vectors++; if (lq_outstanding !== 4'd0) begin miscompares++; $display("FAIL flush_post: got %0d expected 0", lq_outstanding); end
        vectors++; if (lq_mem_data_valid !== 8'h00) begin miscompares++; $display("FAIL flush_late5: got %h expected 00", lq_mem_data_valid); end
        step();
        mem.Dmem2proc_tag = 4'd9; mem.Dmem2proc_data = 64'h99;
        #1;
        vectors++; if (lq_mem_data_valid !== 8'h00) begin miscompares++; $display("FAIL flush_late9: got %h expected 00", lq_mem_data_valid); end
        step();
        mem.Dmem2proc_tag = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        step();
        lq_inuse = 8'h01; lq_addr_valid = 8'h01;
        mem.Dmem2proc_response = 4'd4;
        #1;
        vectors++; if (lq_request2mem !== 8'h01) begin miscompares++; $display("FAIL b2b_acc0: got %h expected 01", lq_request2mem); end
        step();
        lq_inuse = 8'h09; lq_addr_valid = 8'h09; lq_mem_value_valid = 8'h01;
        mem.Dmem2proc_response = 4'd4; mem.Dmem2proc_tag = 4'd4; mem.Dmem2proc_data = 64'hBEEF;
        #1;
        vectors++; if (lq_mem_data_valid !== 8'h01) begin miscompares++; $display("FAIL b2b_dvalid: got %h expected 01", lq_mem_data_valid); end
        vectors++; if (lq_mem_data_out !== 64'hBEEF) begin miscompares++; $display("FAIL b2b_dout: got %h expected beef", lq_mem_data_out); end
        vectors++; if (lq_request2mem !== 8'h08) begin miscompares++; $display("FAIL b2b_acc3: got %h expected 08", lq_request2mem); end
        step();
        mem.Dmem2proc_response = '0; mem.Dmem2proc_tag = '0;
        #1;
        vectors++; if (lq_outstanding !== 4'd1) begin miscompares++; $display("FAIL b2b_outstanding: got %0d expected 1", lq_outstanding); end
        step();
        lq_mem_value_valid = 8'h09;
        mem.Dmem2proc_tag = 4'd4; mem.Dmem2proc_data = 64'h1234;
        #1;
        vectors++; if (lq_mem_data_valid !== 8'h08) begin miscompares++; $display("FAIL b2b_ret3: got %h expected 08", lq_mem_data_valid); end
        vectors++; if (lq_mem_data_out !== 64'h1234) begin miscompares++; $display("FAIL b2b_ret3_data: got %h expected 1234", lq_mem_data_out); end
        step();
        mem.Dmem2proc_tag = '0;
        #1;
        vectors++; if (lq_outstanding !== 4'd0) begin miscompares++; $display("FAIL b2b_drain: got %0d expected 0", lq_outstanding); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        lq_inuse = 8'h04; lq_addr_valid = 8'h04;
        mem.Dmem2proc_response = 4'd6;
        #1;
        vectors++; if (lq_request2mem !== 8'h04) begin miscompares++; $display("FAIL areset_acc: got %h expected 04", lq_request2mem); end
        step();
        mem.Dmem2proc_response = '0;
        #1;
        vectors++; if (lq_outstanding !== 4'd1) begin miscompares++; $display("FAIL areset_pending: got %0d expected 1", lq_outstanding); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (lq_outstanding !== 4'd0) begin miscompares++; $display("FAIL areset_outstanding: got %0d expected 0", lq_outstanding); end
        vectors++; if (mem.proc2Dmem_command !== BUS_NONE) begin miscompares++; $display("FAIL areset_cmd: got %0d expected %0d", mem.proc2Dmem_command, BUS_NONE); end
        step();
        reset = 1'b1;
        lq_mem_value_valid = 8'h04;
        mem.Dmem2proc_tag = 4'd6; mem.Dmem2proc_data = 64'h77;
        #1;
        vectors++; if (lq_mem_data_valid !== 8'h00) begin miscompares++; $display("FAIL areset_drop: got %h expected 00", lq_mem_data_valid); end
        vectors++; if (lq_mem_data_out !== 64'h0) begin miscompares++; $display("FAIL areset_dout: got %h expected 0", lq_mem_data_out); end
        step();
        mem.Dmem2proc_tag = '0;
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_round_robin();
        test_retry();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
